// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access.
// Data wins by default; a waiting fetch is granted once STARVE_MAX data grants have gone by.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              stall_if,
    output logic              stall_m,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int unsigned      CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {StIdle, StIfBusy, StDmBusy} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] starve_cnt;
    logic             grant_dm, grant_if, done_if, done_dm;

    always_comb begin
        state_d  = state_q;
        grant_dm = 1'b0;
        grant_if = 1'b0;
        done_if  = (state_q == StIfBusy) && mem_ack;
        done_dm  = (state_q == StDmBusy) && mem_ack;
        case (state_q)
            StIdle: begin
                // Acks seen here are stray and deliberately ignored.
                grant_dm = dm_req && !(if_req && (starve_cnt == STARVE_LIM));
                grant_if = if_req && !grant_dm;
                if (grant_dm) begin
                    state_d = StDmBusy;
                end else if (grant_if) begin
                    state_d = StIfBusy;
                end
            end
            StIfBusy, StDmBusy: begin
                if (mem_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_valid   <= 1'b0;
            dm_valid   <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            starve_cnt <= '0;
        end else begin
            state_q  <= state_d;
            if_valid <= done_if;
            dm_valid <= done_dm;

            if (grant_dm) begin
                mem_req   <= 1'b1;
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
            end else if (grant_if) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= if_addr;
            end else if (done_if || done_dm) begin
                mem_req <= 1'b0;
            end

            if (done_if) begin
                if_rdata <= mem_rdata;
            end
            if (done_dm && !mem_we) begin
                dm_rdata <= mem_rdata;
            end

            if (!if_req || grant_if) begin
                starve_cnt <= '0;
            end else if (grant_dm && (starve_cnt != STARVE_LIM)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    assign stall_if = if_req & ~if_valid;
    assign stall_m  = dm_req & ~dm_valid;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the ports SHALL be named clk and reset.
REQ-002 The block SHALL have the following parameters, one per line:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, maximum consecutive data grants while a fetch waits
REQ-003 The block SHALL have the following ports, one per line:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- if_req  in  1  instruction-fetch request
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction
- if_valid  out  1  fetch-complete pulse
- dm_req  in  1  data-memory request
- dm_we  in  1  1=write, 0=read
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_rdata  out  DATA_W  read data
- dm_valid  out  1  data-complete pulse
- stall_if  out  1  stall fetch/decode registers
- stall_m  out  1  stall memory and earlier stages
- mem_req  out  1  shared single-port memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_ack  in  1  memory completion, valid for one cycle

Function
REQ-004 The block SHALL implement the FSM states IDLE, IF_BUSY and DM_BUSY, and at most one memory transaction SHALL be outstanding at any time.
REQ-005 In IDLE the block SHALL grant as follows: if dm_req=1 and NOT (if_req=1 and starve_cnt==STARVE_MAX), go to DM_BUSY; else if if_req=1, go to IF_BUSY; else stay in IDLE.
REQ-006 On a grant, the block SHALL register addr/we/wdata from the granted requester into mem_addr/mem_we/mem_wdata and SHALL assert mem_req from the next cycle; for fetches mem_we SHALL be 0.
REQ-007 In the BUSY states, mem_req and the registered mem_* values SHALL be held constant until mem_ack=1, independent of any requester input changes.
REQ-008 When mem_ack=1 in a BUSY state:
- next edge: state goes to IDLE and mem_req=0
- the granted requester's valid SHALL pulse high for exactly one cycle
- for reads, that requester's rdata SHALL register mem_rdata
REQ-009 dm_rdata SHALL update only on read completions; writes SHALL leave it unchanged; if_rdata and dm_rdata SHALL hold their value between completions.
REQ-010 mem_ack SHALL be ignored in IDLE.
REQ-011 A req that is high in the same cycle as that requester's valid pulse SHALL be treated as a new request; a requester SHALL hold req and its operands stable until its valid pulse.
REQ-012 The minimum transaction period SHALL be grant cycle + memory latency + 1 IDLE cycle; there SHALL be no back-to-back issue without passing through IDLE.
REQ-013 starve_cnt (width clog2(STARVE_MAX+1)) SHALL behave as follows:
- increments, saturating at STARVE_MAX, on each DM grant while if_req=1
- clears on each IF grant
- clears in any cycle with if_req=0
REQ-014 The stall outputs SHALL be combinational: stall_if = if_req & ~if_valid; stall_m = dm_req & ~dm_valid.
REQ-015 If dm_req and if_req rise in the same cycle with starve_cnt<STARVE_MAX, data SHALL win.

Reset
REQ-016 On reset=1 at a clock edge the block SHALL set: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_valid=0, dm_valid=0, if_rdata=0, dm_rdata=0, starve_cnt=0.
REQ-017 Reset during a BUSY state SHALL abandon the transaction with no valid pulse; a late mem_ack SHALL then be ignored per REQ-010.
REQ-018 Reset SHALL override all other inputs in the same cycle.

Verification
REQ-019 Single fetch: if_req=1, if_addr=0x10, mem_ack 2 cycles after mem_req, mem_rdata=0x00500093 -> mem_addr=0x10, mem_we=0, if_valid pulses once, if_rdata=0x00500093, stall_if=1 until the pulse.
REQ-020 Write then read: dm write 0x20<-0xDEADBEEF, then dm read 0x20 with memory returning 0xDEADBEEF -> mem_we=1 then 0, dm_rdata unchanged after the write and =0xDEADBEEF after the read.
REQ-021 Simultaneous requests: if_req=dm_req=1 in IDLE with starve_cnt=0 -> DM granted first, IF granted after dm_valid, with 1 IDLE cycle between them.
REQ-022 Starvation: if_req held, dm_req held continuously, STARVE_MAX=4 -> exactly 4 DM grants, then an IF grant, then starve_cnt=0.
REQ-023 Reset mid-transaction: reset during DM_BUSY, mem_ack arrives 1 cycle after reset -> no dm_valid, mem_req=0, state IDLE.
REQ-024 Stray ack: mem_ack=1 in IDLE -> no valid pulse, and rdata outputs unchanged.
